serial_rx: RTL and testbench

Asynchronous 8N1 serial receiver that sits directly upstream of the tweetboard storage stage. It synchronises the raw `serialIn` line and validates the start bit. It samples eight data bits LSB-first at mid-bit and checks the stop bit. Each good byte is presented in a holding register with a valid/ack handshake, so storage logic consumes whole bytes instead of sampling bits itself.

---
 rtl/serial_rx_if.sv | 36 +++
 rtl/serial_rx.sv | 171 +++++++++++++++++
 tb/tb_serial_rx.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_rx_if.sv
// serial_rx_if: byte-delivery bus between the serial receiver and its consumer.
//   rx_data   [7:0] last good byte, bit 0 received first
//   rx_valid        byte pending in the holding register
//   rx_ack          consumer has taken rx_data (meaningful only while rx_valid)
//   frame_err       one-cycle pulse, stop bit sampled low
//   overrun         one-cycle pulse, good byte dropped because one was still pending
//   busy            receiver is inside a frame (not idle)
// master: the receiver side; slave: the consumer side.
interface serial_rx_if;

   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ack;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   modport master (
      output rx_data,
      output rx_valid,
      output frame_err,
      output overrun,
      output busy,
      input  rx_ack
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      input  frame_err,
      input  overrun,
      input  busy,
      output rx_ack
   );

endinterface

// File: rtl/serial_rx.sv
// serial_rx: asynchronous 8N1 receiver feeding the tweetboard storage stage.
// Synchronises the raw line, qualifies the start bit at its mid-point, samples
// eight data bits LSB-first at mid-bit, checks the stop bit and hands each good
// byte over through a valid/ack holding register.
// Ports:
//   sysclk    in   single clock, rising edge
//   reset     in   synchronous, active-high, overrides everything
//   serialIn  in   raw asynchronous line, idle high
//   bus       master modport of serial_rx_if (rx_data, rx_valid, rx_ack,
//             frame_err, overrun, busy); every output comes straight from a flop
//             or from the state register.
module serial_rx #(
   parameter int unsigned CLKS_PER_BIT = 5208,
   parameter int unsigned HALF_BIT     = 2604,
   parameter int unsigned CNT_W        = 13
) (
   input  logic        sysclk,
   input  logic        reset,
   input  logic        serialIn,
   serial_rx_if.master bus
);

   localparam logic [CNT_W-1:0] CntBitEnd  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CntHalfEnd = CNT_W'(HALF_BIT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StWaitIdle
   } state_e;

   state_e           state_q, state_d;
   logic             s1_q, s2_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       sh_q, sh_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic             frame_err_q, frame_err_d;
   logic             overrun_q, overrun_d;

   logic bit_end;
   logic half_end;

   assign bit_end  = (cnt_q == CntBitEnd);
   assign half_end = (cnt_q == CntHalfEnd);

   // Two-flop synchroniser; idles high so reset never looks like a start bit.
   always_ff @(posedge sysclk) begin
      if (reset) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
      end else begin
         s1_q <= serialIn;
         s2_q <= s1_q;
      end
   end

   // State register.
   always_ff @(posedge sysclk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (!s2_q) state_d = StStart;
         end
         StStart: begin
            // A line that is high again at the start mid-point was a glitch.
            if (half_end) state_d = s2_q ? StIdle : StData;
         end
         StData: begin
            if (bit_end && (idx_q == 3'd7)) state_d = StStop;
         end
         StStop: begin
            // Leave at the stop mid-point so a back-to-back start edge is caught.
            if (bit_end) state_d = s2_q ? StIdle : StWaitIdle;
         end
         StWaitIdle: begin
            // A held-low (break) line stays here, yielding a single frame_err.
            if (s2_q) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Datapath and output next values.
   always_comb begin
      cnt_d       = '0;
      idx_d       = idx_q;
      sh_d        = sh_q;
      rx_data_d   = rx_data_q;
      // Ack only matters while a byte is pending.
      rx_valid_d  = rx_valid_q & ~bus.rx_ack;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
      case (state_q)
         StStart: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (half_end) begin
               cnt_d = '0;
               idx_d = 3'd0;
            end
         end
         StData: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (bit_end) begin
               cnt_d = '0;
               sh_d  = {s2_q, sh_q[7:1]};
               idx_d = idx_q + 3'd1;
            end
         end
         StStop: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (bit_end) begin
               cnt_d = '0;
               if (s2_q) begin
                  // Testing the post-ack valid lets a same-cycle ack make room
                  // for the new byte instead of flagging an overrun.
                  if (!rx_valid_d) begin
                     rx_data_d  = sh_q;
                     rx_valid_d = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
               end else begin
                  frame_err_d = 1'b1;
               end
            end
         end
         default: cnt_d = '0;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge sysclk) begin
      if (reset) begin
         cnt_q       <= '0;
         idx_q       <= 3'd0;
         sh_q        <= 8'h00;
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         sh_q        <= sh_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign bus.rx_data   = rx_data_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.frame_err = frame_err_q;
   assign bus.overrun   = overrun_q;
   assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: directed bench for serial_rx using a shortened bit time
// (16 clocks/bit, start check at 8) so each frame takes 160 cycles.
// Stop mid-point edge is t0 + 2 + 8 + 9*16 = t0 + 154.
module tb_serial_rx;

   localparam int CPB      = 16;
   localparam int HB       = 8;
   localparam int CW       = 5;
   localparam int STOP_OFS = 2 + HB + 9 * CPB;

   logic sysclk   = 1'b0;
   logic reset    = 1'b1;
   logic serialIn = 1'b1;

   int checks = 0;
   int errors = 0;
   int edge_n = 0;

   // Monitor state, written only by the negedge monitor.
   int   valid_rises     = 0;
   int   valid_rise_edge = -1;
   int   ferr_cnt        = 0;
   int   ferr_edge       = -1;
   int   ovr_cnt         = 0;
   int   ovr_edge        = -1;
   int   busy_rise_edge  = -1;
   int   busy_fall_edge  = -1;
   logic valid_prev      = 1'b0;
   logic busy_prev       = 1'b0;

   serial_rx_if bus ();

   serial_rx #(
      .CLKS_PER_BIT (CPB),
      .HALF_BIT     (HB),
      .CNT_W        (CW)
   ) dut (
      .sysclk   (sysclk),
      .reset    (reset),
      .serialIn (serialIn),
      .bus      (bus)
   );

   always #5 sysclk = ~sysclk;

   always @(posedge sysclk) edge_n <= edge_n + 1;

   always @(negedge sysclk) begin
      valid_prev <= bus.rx_valid;
      busy_prev  <= bus.busy;
      if (bus.rx_valid === 1'b1 && valid_prev !== 1'b1) begin
         valid_rises     <= valid_rises + 1;
         valid_rise_edge <= edge_n;
      end
      if (bus.frame_err === 1'b1) begin
         ferr_cnt  <= ferr_cnt + 1;
         ferr_edge <= edge_n;
      end
      if (bus.overrun === 1'b1) begin
         ovr_cnt  <= ovr_cnt + 1;
         ovr_edge <= edge_n;
      end
      if (bus.busy === 1'b1 && busy_prev !== 1'b1) busy_rise_edge <= edge_n;
      if (bus.busy === 1'b0 && busy_prev === 1'b1) busy_fall_edge <= edge_n;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   task automatic drive_bit(input logic v);
      serialIn = v;
      tick(CPB);
   endtask

   // t0 is the edge at which the start bit is first captured into s1.
   task automatic send_frame(input logic [7:0] b, input logic stop, output int t0);
      t0 = edge_n + 1;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick(3);
      checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.rx_valid); end
      checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", bus.rx_data); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", bus.frame_err); end
      checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b want 0", bus.overrun); end
      reset = 1'b0;
      tick(4);
   endtask

   task automatic test_basic;
      int t0;
      int r0;
      r0 = valid_rises;
      send_frame(8'h41, 1'b1, t0);
      tick(20);
      checks++; if (valid_rises !== r0 + 1) begin errors++; $display("FAIL basic_rises got %0d want %0d", valid_rises, r0 + 1); end
      checks++; if (valid_rise_edge !== t0 + STOP_OFS) begin errors++; $display("FAIL basic_valid_edge got %0d want %0d", valid_rise_edge, t0 + STOP_OFS); end
      checks++; if (busy_rise_edge !== t0 + 2) begin errors++; $display("FAIL basic_busy_edge got %0d want %0d", busy_rise_edge, t0 + 2); end
      checks++; if (bus.rx_data !== 8'h41) begin errors++; $display("FAIL basic_data got %h want 41", bus.rx_data); end
      checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_held got %b want 1", bus.rx_valid); end
      bus.rx_ack = 1'b1;
      tick(1);
      bus.rx_ack = 1'b0;
      checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL basic_ack got %b want 0", bus.rx_valid); end
      tick(4);
   endtask

   task automatic test_glitch;
      int t0;
      int t1;
      int r0;
      int f0;
      int o0;
      r0 = valid_rises;
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      t0 = edge_n + 1;
      serialIn = 1'b0;
      tick(HB - 2);
      serialIn = 1'b1;
      tick(30);
      checks++; if (busy_rise_edge !== t0 + 2) begin errors++; $display("FAIL glitch_busy_rise got %0d want %0d", busy_rise_edge, t0 + 2); end
      checks++; if (busy_fall_edge !== t0 + 2 + HB) begin errors++; $display("FAIL glitch_busy_fall got %0d want %0d", busy_fall_edge, t0 + 2 + HB); end
      checks++; if (valid_rises !== r0) begin errors++; $display("FAIL glitch_valid got %0d want %0d", valid_rises, r0); end
      checks++; if (ferr_cnt !== f0 || ovr_cnt !== o0) begin errors++; $display("FAIL glitch_pulses got ferr %0d ovr %0d want %0d %0d", ferr_cnt, ovr_cnt, f0, o0); end
      send_frame(8'h08, 1'b1, t1);
      tick(10);
      checks++; if (bus.rx_data !== 8'h08) begin errors++; $display("FAIL glitch_next_data got %h want 08", bus.rx_data); end
      checks++; if (valid_rise_edge !== t1 + STOP_OFS) begin errors++; $display("FAIL glitch_next_edge got %0d want %0d", valid_rise_edge, t1 + STOP_OFS); end
      bus.rx_ack = 1'b1;
      tick(1);
      bus.rx_ack = 1'b0;
      tick(4);
   endtask

   task automatic test_frame_err;
      int t0;
      int r0;
      int f0;
      r0 = valid_rises;
      f0 = ferr_cnt;
      send_frame(8'h55, 1'b0, t0);
      tick(400);
      checks++; if (ferr_cnt !== f0 + 1) begin errors++; $display("FAIL ferr_count got %0d want %0d", ferr_cnt, f0 + 1); end
      checks++; if (ferr_edge !== t0 + STOP_OFS) begin errors++; $display("FAIL ferr_edge got %0d want %0d", ferr_edge, t0 + STOP_OFS); end
      checks++; if (valid_rises !== r0) begin errors++; $display("FAIL ferr_valid got %0d want %0d", valid_rises, r0); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ferr_wait_busy got %b want 1", bus.busy); end
      serialIn = 1'b1;
      tick(5);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ferr_release_busy got %b want 0", bus.busy); end
      checks++; if (ferr_cnt !== f0 + 1) begin errors++; $display("FAIL ferr_count_after got %0d want %0d", ferr_cnt, f0 + 1); end
   endtask

   task automatic test_back_to_back;
      int t0;
      int t1;
      int r0;
      int o0;
      r0 = valid_rises;
      o0 = ovr_cnt;
      send_frame(8'h30, 1'b1, t0);
      send_frame(8'h31, 1'b1, t1);
      tick(10);
      checks++; if (valid_rises !== r0 + 1) begin errors++; $display("FAIL b2b_rises got %0d want %0d", valid_rises, r0 + 1); end
      checks++; if (valid_rise_edge !== t0 + STOP_OFS) begin errors++; $display("FAIL b2b_valid_edge got %0d want %0d", valid_rise_edge, t0 + STOP_OFS); end
      checks++; if (ovr_cnt !== o0 + 1) begin errors++; $display("FAIL b2b_ovr_count got %0d want %0d", ovr_cnt, o0 + 1); end
      checks++; if (ovr_edge !== t1 + STOP_OFS) begin errors++; $display("FAIL b2b_ovr_edge got %0d want %0d", ovr_edge, t1 + STOP_OFS); end
      checks++; if (bus.rx_data !== 8'h30) begin errors++; $display("FAIL b2b_data got %h want 30", bus.rx_data); end
      checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", bus.rx_valid); end
   endtask

   // Enters with 0x30 still pending, so reset has a visible byte to clear.
   task automatic test_reset_mid;
      int t1;
      int r0;
      int f0;
      logic [7:0] b;
      b = 8'h7E;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(b[i]);
      serialIn = b[4];
      tick(CPB / 2);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b want 1", bus.busy); end
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", bus.rx_valid); end
      checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h want 00", bus.rx_data); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
      checks++; if (bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin errors++; $display("FAIL rstmid_pulses got %b%b want 00", bus.frame_err, bus.overrun); end
      r0 = valid_rises;
      f0 = ferr_cnt;
      serialIn = 1'b1;
      tick(200);
      checks++; if (valid_rises !== r0 || ferr_cnt !== f0) begin errors++; $display("FAIL rstmid_partial got rises %0d ferr %0d want %0d %0d", valid_rises, ferr_cnt, r0, f0); end
      send_frame(8'hA5, 1'b1, t1);
      tick(10);
      checks++; if (bus.rx_data !== 8'hA5) begin errors++; $display("FAIL rstmid_next_data got %h want a5", bus.rx_data); end
      checks++; if (valid_rise_edge !== t1 + STOP_OFS) begin errors++; $display("FAIL rstmid_next_edge got %0d want %0d", valid_rise_edge, t1 + STOP_OFS); end
   endtask

   // Enters with 0xA5 pending; ack lands on the 0x62 delivery edge.
   task automatic test_ack_collision;
      int t0;
      int r0;
      int o0;
      r0 = valid_rises;
      o0 = ovr_cnt;
      fork
         send_frame(8'h62, 1'b1, t0);
         begin
            tick(STOP_OFS);
            bus.rx_ack = 1'b1;
            tick(1);
            bus.rx_ack = 1'b0;
         end
      join
      tick(5);
      checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL collide_valid got %b want 1", bus.rx_valid); end
      checks++; if (bus.rx_data !== 8'h62) begin errors++; $display("FAIL collide_data got %h want 62", bus.rx_data); end
      checks++; if (ovr_cnt !== o0) begin errors++; $display("FAIL collide_ovr got %0d want %0d", ovr_cnt, o0); end
      checks++; if (valid_rises !== r0) begin errors++; $display("FAIL collide_no_gap got %0d want %0d", valid_rises, r0); end
      bus.rx_ack = 1'b1;
      tick(1);
      bus.rx_ack = 1'b0;
      checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL collide_final_ack got %b want 0", bus.rx_valid); end
   endtask

   initial begin
      bus.rx_ack = 1'b0;
      test_reset();
      test_basic();
      test_glitch();
      test_frame_err();
      test_back_to_back();
      test_reset_mid();
      test_ack_collision();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
